// File: rtl/prio_encoder_q.sv
// rtl/prio_encoder_q.sv - registered priority encoder with pending-request capture and ack
// Arbitration: fixed highest-index by default, round-robin when ROUND_ROBIN_EN is defined.
module prio_encoder_q #(
  parameter int WIDTH = 16,
  parameter int ZW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EI,
  input  logic [WIDTH-1:0] I,
  input  logic             ack,
  output logic [ZW-1:0]    Z,
  output logic             GS,
  output logic             EO
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] pn;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;
  logic             accept;
  logic             found;
  logic [ZW-1:0]    sel;

`ifdef ROUND_ROBIN_EN
  logic [ZW-1:0]    ptr;
  logic [ZW-1:0]    ptr_n;
`endif

  always_comb begin
    accept = ack & ~GS & ~EI;
    clr    = '0;
    if (accept) clr[Z] = 1'b1;
    set    = EI ? '0 : ~I;
    // set is ORed last so a re-request on the acked bit keeps it pending
    pn     = (p & ~clr) | set;
    found  = 1'b0;
    sel    = '0;
`ifdef ROUND_ROBIN_EN
    ptr_n  = accept ? Z : ptr;
    // walk downward from ptr_n-1; modulo-2^ZW subtraction gives the wrap to WIDTH-1
    for (int k = 1; k <= WIDTH; k++) begin
      if (!found && pn[ptr_n - ZW'(k)]) begin
        found = 1'b1;
        sel   = ptr_n - ZW'(k);
      end
    end
`else
    for (int i = 0; i < WIDTH; i++) begin
      if (pn[i]) begin
        found = 1'b1;
        sel   = ZW'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p  <= '0;
      Z  <= '0;
      GS <= 1'b1;
      EO <= 1'b1;
`ifdef ROUND_ROBIN_EN
      ptr <= '0;
`endif
    end else begin
      p <= pn;
`ifdef ROUND_ROBIN_EN
      ptr <= ptr_n;
`endif
      if (EI) begin
        Z  <= '0;
        GS <= 1'b1;
        EO <= 1'b1;
      end else if (found) begin
        Z  <= sel;
        GS <= 1'b0;
        EO <= 1'b1;
      end else begin
        Z  <= '0;
        GS <= 1'b1;
        EO <= 1'b0;
      end
    end
  end

endmodule

// File: doc/prio_encoder_q.md
PRIO_ENCODER_Q -- requirements
Module: prio_encoder_q

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the number of request inputs; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have parameter ZW, default 4, giving the width of the index output; it must equal log2(WIDTH).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 Port EI  input  1  SHALL be the enable, active-low; 0 means enabled.
REQ-006 Port I  input  WIDTH  SHALL carry the request lines, active-low; bit i = 0 requests channel i.
REQ-007 Port ack  input  1  SHALL be the active-high acknowledge of the currently presented index.
REQ-008 Port Z  output  ZW  SHALL carry the registered binary index of the selected pending channel, true polarity.
REQ-009 Port GS  output  1  SHALL be the registered group-select, active-low; 0 means Z is valid.
REQ-010 Port EO  output  1  SHALL be the registered enable-out, active-low; 0 means enabled and nothing pending.

Function
REQ-011 The block SHALL hold a WIDTH-bit pending register P; next value Pn = (P & ~clr) | set.
REQ-012 set[i] SHALL be 1 when EI=0 and I[i]=0; EI=1 blocks all capture.
REQ-013 clr SHALL be one-hot at index Z when ack=1, GS=0 and EI=0; otherwise clr SHALL be zero. ack with GS=1 or EI=1 SHALL be ignored.
REQ-014 When set and clr hit the same bit in one cycle, set SHALL win and the bit SHALL remain pending.
REQ-015 Z, GS and EO SHALL be registered from Pn at the same edge that loads P; latency is 1 edge from request sample to GS=0.
REQ-016 In fixed mode, selection SHALL be the highest-index set bit of Pn.
REQ-017 With EI=0 and Pn nonzero: GS=0, EO=1, Z=selected index.
REQ-018 With EI=0 and Pn zero: GS=1, EO=0, Z=0.
REQ-019 With EI=1: GS=1, EO=1, Z=0; P SHALL be retained unchanged.
REQ-020 A request held low across many cycles SHALL re-set its bit each cycle, so it is re-granted after ack.
REQ-021 No X SHALL be produced on Z, GS or EO for any input pattern once reset has been applied.

Reset
REQ-022 On an edge with rst_n=0: P=0, Z=0, GS=1, EO=1, round-robin pointer=0; reset SHALL override all other inputs.
REQ-023 A reset asserted mid-operation SHALL discard all pending requests; the first edge after release SHALL behave as from power-up.

Configuration
REQ-024 Macro ROUND_ROBIN_EN SHALL select the arbitration mode at compile time.
REQ-025 Without ROUND_ROBIN_EN: fixed highest-index priority (REQ-016); no pointer register SHALL exist.
REQ-026 With ROUND_ROBIN_EN: a ZW-bit pointer ptr SHALL load Z on every accepted ack.
REQ-027 With ROUND_ROBIN_EN: selection SHALL be the first set bit of Pn searching downward from ptr-1, wrapping from 0 to WIDTH-1.
REQ-028 With ROUND_ROBIN_EN: ptr=0 searches from WIDTH-1, identical to fixed mode, and wrap-around from bit 0 to WIDTH-1 SHALL be seamless.

Verification (WIDTH=16)
REQ-029 Reset, EI=0, I=16'h3503 for one cycle then I=16'hFFFF -> after one edge Z=15, GS=0, EO=1; ack every cycle -> Z sequence 15,14,11,9,7,6,5,4,3,2, then GS=1, EO=0.
REQ-030 EI=1, I=16'h0FFF, with P holding bit 5 -> Z=0, GS=1, EO=1 while EI=1; after EI=0, Z=5, GS=0, and bits 15..12 are not captured.
REQ-031 EI=0, I=16'hFFFD -> Z=1, GS=0; ack with I=16'hFFFF -> GS=1, EO=0 next edge.
REQ-032 Bit 7 pending, ack asserted while I[7]=0 in the same cycle -> Z stays 7, GS stays 0.
REQ-033 Bits 11 and 4 pending, rst_n=0 for one edge -> P=0, GS=1, EO=1; after release with I=16'hFFFF, EO=0.
REQ-034 I[9] and I[3] held low, ack every cycle -> fixed mode Z=9 every cycle; ROUND_ROBIN_EN Z=9,3,9,3.
